// File: rtl/lc_pkg.sv
// lc_pkg: shared types and constants for the prefetching location counter.
package lc_pkg;
    typedef enum logic [1:0] {EMPTY, REQ, STALE, FULL} lc_state_t;
    localparam logic [1:0] LC_MODE_WORD = 2'd0;
    localparam logic [1:0] LC_MODE_HALF = 2'd1;
    localparam logic [1:0] LC_MODE_UNIT = 2'd2;
    localparam int RD_W = 32;
endpackage

// File: rtl/lc_step.sv
// lc_step: next-lc adder for the three step modes, with carry into the word field.
module lc_step
    import lc_pkg::*;
#(
    parameter int LC_W      = 26,
    parameter int UNIT_LOG2 = 2
) (
    input  logic [LC_W-1:0] lc,
    input  logic [1:0]      mode,
    input  logic            inc,
    output logic [LC_W-1:0] nxt,
    output logic            carry
);
    localparam logic [UNIT_LOG2:0] ONE = 1;
    logic [UNIT_LOG2:0] step;
    logic [UNIT_LOG2:0] sum;
    // A word step is a full 2^UNIT_LOG2 add: it always carries and leaves the unit bits alone.
    assign step  = mode == LC_MODE_HALF ? ONE << (UNIT_LOG2 - 1) :
                   mode == LC_MODE_UNIT ? ONE : ONE << UNIT_LOG2;
    assign sum   = {1'b0, lc[UNIT_LOG2-1:0]} + step;
    assign carry = inc & sum[UNIT_LOG2];
    assign nxt   = inc ? {lc[LC_W-1:UNIT_LOG2] + (LC_W-UNIT_LOG2)'(sum[UNIT_LOG2]), sum[UNIT_LOG2-1:0]} : lc;
endmodule

// File: rtl/lc_prefetch.sv
// lc_prefetch: location counter with a one-word instruction prefetch buffer and fetch handshake.
module lc_prefetch
    import lc_pkg::*;
#(
    parameter int LC_W      = 26,
    parameter int UNIT_LOG2 = 2,
    parameter int DATA_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      lc_load,
    input  logic [LC_W-1:0]           lc_load_val,
    input  logic                      lc_inc,
    input  logic [1:0]                lc_mode,
    output logic [LC_W-1:0]           lc,
    output logic                      needfetch,
    output logic                      fetch_req,
    output logic [LC_W-UNIT_LOG2-1:0] fetch_addr,
    input  logic                      fetch_ack,
    input  logic [DATA_W-1:0]         fetch_data,
    output logic                      ibuf_valid,
    output logic                      stall,
    output logic [DATA_W/2-1:0]       instr,
    output logic [RD_W-1:0]           rd_word
);
    lc_state_t         state;
    logic [DATA_W-1:0] ibuf;
    logic [1:0]        mode_q;
    logic [LC_W-1:0]   step_lc;
    logic [LC_W-1:0]   next_lc;
    logic              carry;
    logic              inv;

    lc_step #(.LC_W(LC_W), .UNIT_LOG2(UNIT_LOG2)) u_step (
        .lc(lc), .mode(lc_mode), .inc(lc_inc), .nxt(step_lc), .carry(carry)
    );

    assign next_lc   = lc_load ? lc_load_val : step_lc;
    assign needfetch = carry;
    assign inv       = lc_load | carry;
    assign stall     = ~ibuf_valid;
    assign instr     = lc[UNIT_LOG2-1] ? ibuf[DATA_W-1:DATA_W/2] : ibuf[DATA_W/2-1:0];
    assign rd_word   = {ibuf_valid, fetch_req, mode_q, 28'(lc)};

    // fetch_addr only moves when a new request is launched, so it is stable while fetch_req is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            lc         <= '0;
            mode_q     <= '0;
            fetch_req  <= 1'b0;
            fetch_addr <= '0;
            ibuf       <= '0;
            ibuf_valid <= 1'b0;
        end else begin
            lc     <= next_lc;
            mode_q <= lc_mode;
            case (state)
                EMPTY: begin
                    state      <= REQ;
                    fetch_req  <= 1'b1;
                    fetch_addr <= next_lc[LC_W-1:UNIT_LOG2];
                end
                REQ: begin
                    if (fetch_ack && inv) begin
                        fetch_addr <= next_lc[LC_W-1:UNIT_LOG2];
                    end else if (fetch_ack) begin
                        state      <= FULL;
                        fetch_req  <= 1'b0;
                        ibuf       <= fetch_data;
                        ibuf_valid <= 1'b1;
                    end else if (inv) begin
                        state <= STALE;
                    end
                end
                STALE: begin
                    if (fetch_ack) begin
                        state     <= EMPTY;
                        fetch_req <= 1'b0;
                    end
                end
                FULL: begin
                    if (inv) begin
                        state      <= REQ;
                        fetch_req  <= 1'b1;
                        fetch_addr <= next_lc[LC_W-1:UNIT_LOG2];
                        ibuf_valid <= 1'b0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: doc/lc_prefetch.md
# lc_prefetch

Parametrised location counter with an integrated one-word instruction prefetch buffer. Successor to the fixed 26-bit LC: counter width, sub-word granularity and fetch data width are generic, and it adds three step modes plus its own memory-fetch handshake in place of an externally supplied needfetch. Sits between the sequencer, which loads and advances the LC, and the memory interface, which returns instruction words. It also produces the LC read-back word for the MF source mux.

## Interface
- LC_W, 26: location counter width in sub-word units; must be ≤ 28.
- UNIT_LOG2, 2: log2 of sub-word units per memory word; must be ≥ 1.
- DATA_W, 32: fetch word width; must be even. Instruction width is DATA_W/2.
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- lc_load  in  1  load `lc_load_val` into the LC.
- lc_load_val  in  LC_W  new LC value.
- lc_inc  in  1  advance the LC by one step of the current mode.
- lc_mode  in  2  step mode: 0 = word (2^UNIT_LOG2), 1 = half (2^(UNIT_LOG2-1)), 2 = unit (1), 3 = word.
- lc  out  LC_W  current location counter.
- needfetch  out  1  combinational; the requested advance carries into the word address.
- fetch_req  out  1  memory read request.
- fetch_addr  out  LC_W-UNIT_LOG2  registered word address of the request.
- fetch_ack  in  1  memory accepts the request and returns `fetch_data` in the same cycle.
- fetch_data  in  DATA_W  fetched word.
- ibuf_valid  out  1  the buffer holds the word addressed by `lc`.
- stall  out  1  equals ~ibuf_valid.
- instr  out  DATA_W/2  buffer half selected by bit `lc[UNIT_LOG2-1]` (1 selects the upper half).
- rd_word  out  32  {ibuf_valid, fetch_req, lc_mode, zero pad, lc}.

## Operation
Counter behaviour:
- lc_load has priority over lc_inc.
- On lc_inc, the unit field is `lc[UNIT_LOG2-1:0] + step`.
- A carry out of the unit field increments the word field. The word field wraps modulo 2^(LC_W-UNIT_LOG2).
- Word mode always carries; the unit bits are unchanged.
- An invalidating event ("inv") is either a load or an advance that carries.
- A load of an address in the same word still counts as inv; the buffer is refetched.

FSM states:
- EMPTY: fetch_req = 0. Next state is REQ, with fetch_addr taken from the word field of next-lc.
- REQ: fetch_req = 1; fetch_addr holds stable.
  - ack without inv: FULL; ibuf loads fetch_data.
  - ack with inv: data is discarded; next state is REQ with the new address.
  - inv without ack: STALE.
- STALE: fetch_req = 1, old fetch_addr held; further inv events only update lc.
  - On ack: data is discarded; next state is EMPTY.
- FULL: ibuf_valid = 1.
  - inv: next state is REQ with the new word address. The buffer is invalid from the next cycle.

Handshake rules:
- While fetch_req is high, fetch_addr never changes.
- A request is never withdrawn except by reset.

Other rules:
- lc_inc is honoured even while stalled. The sequencer must gate lc_inc with stall.
- rd_word packs bits: [31] ibuf_valid, [30] fetch_req, [29:28] lc_mode, [27:LC_W] zero, [LC_W-1:0] lc.

## Timing
- Reset values:
  - lc = 0, state = EMPTY.
  - fetch_req = 0, fetch_addr = 0.
  - ibuf = 0, ibuf_valid = 0, so stall = 1.
- First request is asserted on the first cycle after reset_n deasserts.
- Best-case fetch: request in cycle N, ack in cycle N, ibuf_valid high in cycle N+1.
- From FULL: inv in cycle N, request in cycle N+1, so best-case valid again in cycle N+2.
- needfetch, instr and stall are combinational from current state and inputs. All other outputs are registered.
- Reset asserted mid-request drops fetch_req asynchronously. The memory side must tolerate an abandoned request.

## Structure
- Package `lc_pkg`:
  - State enum {EMPTY, REQ, STALE, FULL}.
  - Mode constants LC_MODE_WORD/HALF/UNIT.
  - RD_W = 32.
- Sub-module `lc_step`: combinational step adder. Takes lc, mode and inc; produces next-lc and carry. Instantiated once.
- FSM, buffer and rd_word packing live in the top level.

## Test plan
All scenarios use defaults (LC_W=26, UNIT_LOG2=2, DATA_W=32).
- Reset release: fetch_req rises next cycle with fetch_addr=0. Ack with 0xDEADBEEF gives, next cycle, ibuf_valid=1, instr=0xBEEF, rd_word=0x90000000 (lc_mode=1).
- Half mode from lc=0: inc gives lc=2, instr=0xDEAD, needfetch=0. Second inc gives needfetch=1, lc=4, ibuf_valid=0 next cycle, then req with addr=1.
- Unit mode from lc=3: inc gives lc=4 with carry. Word mode from lc=5: inc gives lc=9 with carry.
- In REQ at addr 0, load 0x100 without ack: STALE, req held at addr 0. Ack: data dropped, then EMPTY, then REQ addr 0x40.
- Load and inc in the same cycle: load wins. Load in the same cycle as ack: data discarded, REQ at the new address next cycle.
- lc=0x3FFFFFE, half mode: inc gives lc=0, needfetch=1, refetch at addr 0.
